// File: rtl/lifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lifo_pkg
// Description : Shared types and constants for the LIFO read-side packer.
// Revision    : 1.0 - initial release
// ============================================================================
package lifo_pkg;

    // Data width of the upstream 8-bit LIFO.
    localparam int BYTE_W = 8;

    // Packer control states.
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/lifo_byte_lane_reg.sv
`default_nettype none
// ============================================================================
// Module      : lifo_byte_lane_reg
// Description : Word register made of byte lanes. A write lands in the lane
//               selected by idx_i; clear zeroes every lane at once.
// Revision    : 1.0 - initial release
// ============================================================================
module lifo_byte_lane_reg #(
    parameter int BYTES_PER_WORD = 4,
    parameter int BYTE_W         = 8,
    parameter int IDX_W          = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr_i,
    input  logic                             wr_i,
    input  logic [IDX_W-1:0]                 idx_i,
    input  logic [BYTE_W-1:0]                byte_i,
    output logic [BYTES_PER_WORD*BYTE_W-1:0] word_o
);

    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
        logic [BYTE_W-1:0] lane_q;

        // Lane storage: clear wins over a capture so a finished word never leaks a byte.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lane_q <= '0;
            end else if (clr_i) begin
                lane_q <= '0;
            end else if (wr_i && (idx_i == IDX_W'(gi))) begin
                lane_q <= byte_i;
            end
        end

        assign word_o[gi*BYTE_W +: BYTE_W] = lane_q;
    end

endmodule
`default_nettype wire

// File: rtl/lifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module      : lifo_rd_packer
// Description : Pops bytes from an 8-bit LIFO (one-cycle read latency) and
//               packs BYTES_PER_WORD of them into a word on a valid/ready
//               port. A flush pulse emits a partially filled word.
//               Optional macro LIFO_RD_STATS_EN adds word/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module lifo_rd_packer
    import lifo_pkg::*;
#(
    parameter int BYTES_PER_WORD = 4,
    parameter int BYTE_W         = lifo_pkg::BYTE_W
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     lifo_empty,
    input  logic [BYTE_W-1:0]                        lifo_data,
    output logic                                     lifo_rd_en,
    input  logic                                     flush,
    output logic [BYTE_W*BYTES_PER_WORD-1:0]         out_data,
    output logic [$clog2(BYTES_PER_WORD+1)-1:0]      out_bytes,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic                                     busy
`ifdef LIFO_RD_STATS_EN
    ,
    output logic [15:0]                              word_count,
    output logic [7:0]                               flush_count
`endif
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD + 1);

    rd_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             flush_req_q, flush_req_d;
    logic             out_valid_q, out_valid_d;

    logic             rd_req;
    logic             cap;
    logic             clr;
    logic             flush_hit;
    logic             handshake;
    logic [CNT_W:0]   inflight;

    // Bytes already captured plus the one still coming back from the LIFO.
    assign inflight  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, pend_q};
    // A flush only matters when there is something to push out.
    assign flush_hit = flush && ((cnt_q != '0) || pend_q);
    assign handshake = out_valid_q && out_ready;

    // State and credit registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            flush_req_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            flush_req_q <= flush_req_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state, pop request and lane-capture control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = 1'b0;
        flush_req_d = flush_req_q;
        out_valid_d = out_valid_q;
        rd_req      = 1'b0;
        cap         = 1'b0;
        clr         = 1'b0;

        case (state_q)
            FILL: begin
                // Never over-read: at most BYTES_PER_WORD bytes owned in total.
                rd_req = !lifo_empty
                         && (inflight < (CNT_W+1)'(BYTES_PER_WORD))
                         && !flush_req_q && !flush_hit;
                pend_d = rd_req;
                if (pend_q) begin
                    cap   = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (pend_q && (cnt_q == CNT_W'(BYTES_PER_WORD - 1))) begin
                    // Word completes this cycle; a coincident flush adds nothing.
                    state_d     = HOLD;
                    out_valid_d = 1'b1;
                end else if (flush_hit) begin
                    flush_req_d = 1'b1;
                    if (pend_q) begin
                        state_d = DRAIN;
                    end else begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                    end
                end
            end

            DRAIN: begin
                // Pick up any byte still in flight, then present the word.
                if (pend_q) begin
                    cap   = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
                state_d     = HOLD;
                out_valid_d = 1'b1;
            end

            HOLD: begin
                if (handshake) begin
                    cnt_d       = '0;
                    clr         = 1'b1;
                    flush_req_d = 1'b0;
                    out_valid_d = 1'b0;
                    state_d     = FILL;
                end
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    lifo_byte_lane_reg #(
        .BYTES_PER_WORD (BYTES_PER_WORD),
        .BYTE_W         (BYTE_W),
        .IDX_W          (CNT_W)
    ) u_lanes (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .wr_i   (cap),
        .idx_i  (cnt_q),
        .byte_i (lifo_data),
        .word_o (out_data)
    );

    // The pop request is combinational, so hold it low while reset is asserted.
    assign lifo_rd_en = rd_req && !rst;
    assign out_valid  = out_valid_q;
    assign out_bytes  = out_valid_q ? cnt_q : '0;
    assign busy       = (cnt_q != '0) || pend_q || out_valid_q;

`ifdef LIFO_RD_STATS_EN
    logic [15:0] word_count_q;
    logic [7:0]  flush_count_q;

    // Handshake counters: total words wraps, flushed words saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count_q  <= '0;
            flush_count_q <= '0;
        end else if (handshake) begin
            word_count_q <= word_count_q + 16'd1;
            if (flush_req_q && (flush_count_q != 8'hFF)) begin
                flush_count_q <= flush_count_q + 8'd1;
            end
        end
    end

    assign word_count  = word_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lifo_rd_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lifo_rd_packer
// Description : Self-checking bench for lifo_rd_packer. A LIFO model feeds
//               the packer; a reference model groups popped bytes into
//               expected words which a monitor compares on every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lifo_rd_packer;

    localparam int BPW = 4;
    localparam int BW  = 8;
    localparam int SBN = 1024;

    logic            clk;
    logic            rst;
    logic            lifo_empty;
    logic [BW-1:0]   lifo_data;
    logic            lifo_rd_en;
    logic            flush;
    logic [BW*BPW-1:0] out_data;
    logic [2:0]      out_bytes;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
`ifdef LIFO_RD_STATS_EN
    logic [15:0]     word_count;
    logic [7:0]      flush_count;
`endif

    lifo_rd_packer #(
        .BYTES_PER_WORD (BPW),
        .BYTE_W         (BW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lifo_empty (lifo_empty),
        .lifo_data  (lifo_data),
        .lifo_rd_en (lifo_rd_en),
        .flush      (flush),
        .out_data   (out_data),
        .out_bytes  (out_bytes),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
`ifdef LIFO_RD_STATS_EN
        ,
        .word_count (word_count),
        .flush_count(flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LIFO model storage
    logic [BW-1:0] stack [0:63];
    int            push_cnt;
    int            pop_cnt;
    logic [BW-1:0] nb;
    bit            pop_pend;
    assign lifo_empty = (push_cnt == pop_cnt);

    // Reference model / scoreboard
    logic [63:0]   exp_data  [0:SBN-1];
    int            exp_bytes [0:SBN-1];
    bit            exp_fl    [0:SBN-1];
    int            wr_ptr;
    int            rd_ptr;
    logic [BW-1:0] acc_b [0:7];
    int            acc_n;
    int            hs_n;
    int            fl_n;

    int            n_chk;
    int            n_pass;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic emit(input bit fl);
        logic [63:0] d;
        d = '0;
        for (int j = 0; j < acc_n; j++) d = d | (64'(acc_b[j]) << (8*j));
        exp_data[wr_ptr % SBN]  = d;
        exp_bytes[wr_ptr % SBN] = acc_n;
        exp_fl[wr_ptr % SBN]    = fl;
        wr_ptr++;
        acc_n = 0;
    endtask

    task automatic push(input logic [BW-1:0] b);
        stack[push_cnt - pop_cnt] = b;
        push_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        for (int i = 0; i < 40; i++) begin
            if (out_valid) break;
            tick();
        end
        chk({nm, "_valid"}, 64'(out_valid), 64'd1);
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 80; i++) begin
            if (!busy) break;
            tick();
        end
        chk({nm, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic       rdv [0:7];
        logic       ovv [0:7];
        int         nrd;
        logic [7:0] b [0:3];

        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        lifo_data = '0;
        push_cnt  = 0;
        pop_cnt   = 0;
        pop_pend  = 1'b0;
        wr_ptr    = 0;
        rd_ptr    = 0;
        acc_n     = 0;
        hs_n      = 0;
        fl_n      = 0;
        n_chk     = 0;
        n_pass    = 0;
        nb        = '0;

        fork
            // ---------------- stimulus ----------------
            begin
                @(posedge clk);
                @(posedge clk);
                #1;
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_out_data",  64'(out_data),  64'd0);
                chk("rst_out_bytes", 64'(out_bytes), 64'd0);
                chk("rst_busy",      64'(busy),      64'd0);
                chk("rst_rd_en",     64'(lifo_rd_en),64'd0);
                rst = 1'b0;
                tick();

                // Full word with latency check
                out_ready = 1'b1;
                push(8'h11); push(8'h22); push(8'h33); push(8'h44);
                for (int c = 0; c < 8; c++) begin
                    @(negedge clk);
                    rdv[c] = lifo_rd_en;
                    ovv[c] = out_valid;
                end
                chk("t1_rd_first",   64'(rdv[0]), 64'd1);
                chk("t1_rd_4th",     64'(rdv[3]), 64'd1);
                chk("t1_no_5th_rd",  64'(rdv[4]), 64'd0);
                chk("t1_valid_c4",   64'(ovv[4]), 64'd0);
                chk("t1_valid_c5",   64'(ovv[5]), 64'd1);
                chk("t1_valid_c6",   64'(ovv[6]), 64'd0);
                tick();
                wait_idle("t1");

                // Backpressure
                out_ready = 1'b0;
                push(8'h11); push(8'h22); push(8'h33); push(8'h44);
                for (int i = 0; i < 15; i++) tick();
                chk("t2_held_valid", 64'(out_valid),  64'd1);
                chk("t2_held_data",  64'(out_data),   64'h11223344);
                chk("t2_held_bytes", 64'(out_bytes),  64'd4);
                chk("t2_held_no_rd", 64'(lifo_rd_en), 64'd0);
                out_ready = 1'b1;
                tick();
                chk("t2_accepted",   64'(out_valid),  64'd0);
                wait_idle("t2");

                // Partial flush
                push(8'hA5); push(8'h5A);
                for (int i = 0; i < 6; i++) tick();
                chk("t3_partial_busy",  64'(busy),      64'd1);
                chk("t3_partial_novld", 64'(out_valid), 64'd0);
                pulse_flush();
                wait_valid("t3");
                chk("t3_data",  64'(out_data),  64'h0000A55A);
                chk("t3_bytes", 64'(out_bytes), 64'd2);
                tick();
                wait_idle("t3");

                // Flush with a read in flight
                push(8'h01); push(8'h02); push(8'h03); push(8'h04);
                nrd = 0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (lifo_rd_en) nrd++;
                    if (nrd == 3) break;
                end
                @(posedge clk);
                #1;
                flush = 1'b1;
                @(negedge clk);
                chk("t4_no_4th_rd", 64'(lifo_rd_en), 64'd0);
                @(posedge clk);
                #1;
                flush = 1'b0;
                wait_valid("t4");
                chk("t4_data",  64'(out_data),  64'h00020304);
                chk("t4_bytes", 64'(out_bytes), 64'd3);
                tick();
                for (int i = 0; i < 5; i++) tick();
                pulse_flush();
                wait_valid("t4_left");
                chk("t4_left_data", 64'(out_data), 64'h01);
                tick();
                wait_idle("t4");

                // Empty stall and ignored flush
                pulse_flush();
                for (int i = 0; i < 4; i++) tick();
                chk("t5_ign_valid", 64'(out_valid), 64'd0);
                chk("t5_ign_busy",  64'(busy),      64'd0);
                push(8'h77);
                for (int i = 0; i < 6; i++) tick();
                chk("t5_one_busy",  64'(busy),      64'd1);
                chk("t5_one_novld", 64'(out_valid), 64'd0);
                pulse_flush();
                wait_valid("t5");
                chk("t5_data",  64'(out_data),  64'h77);
                chk("t5_bytes", 64'(out_bytes), 64'd1);
                tick();
                wait_idle("t5");

                // Asynchronous reset mid-word
                push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
                for (int i = 0; i < 4; i++) @(posedge clk);
                #3;
                rst = 1'b1;
                #1;
                chk("t6_rst_valid", 64'(out_valid),  64'd0);
                chk("t6_rst_data",  64'(out_data),   64'd0);
                chk("t6_rst_bytes", 64'(out_bytes),  64'd0);
                chk("t6_rst_busy",  64'(busy),       64'd0);
                chk("t6_rst_rd",    64'(lifo_rd_en), 64'd0);
                @(posedge clk);
                @(posedge clk);
                #1;
                rst = 1'b0;
`ifdef LIFO_RD_STATS_EN
                chk("t6_word_count", 64'(word_count), 64'd0);
`endif
                tick();
                for (int i = 0; i < 4; i++) begin
                    b[i] = 8'($urandom);
                    push(b[i]);
                end
                wait_valid("t6");
                chk("t6_data", 64'(out_data), 64'({b[0], b[1], b[2], b[3]}));
                tick();
                wait_idle("t6");

                // Randomized traffic
                for (int i = 0; i < 500; i++) begin
                    if (($urandom_range(0, 2) == 0) && ((push_cnt - pop_cnt) < 60))
                        push(8'($urandom));
                    out_ready = ($urandom_range(0, 3) != 0);
                    flush     = !flush && ($urandom_range(0, 15) == 0);
                    tick();
                end
                flush     = 1'b0;
                out_ready = 1'b1;
                for (int i = 0; i < 400; i++) begin
                    if (lifo_empty && !busy) break;
                    flush = ((i % 10) == 0);
                    tick();
                end
                flush = 1'b0;
                tick();
                wait_idle("drain");
                chk("sb_all_words_seen", 64'(wr_ptr - rd_ptr), 64'd0);
`ifdef LIFO_RD_STATS_EN
                chk("word_count",  64'(word_count),  64'(hs_n));
                chk("flush_count", 64'(flush_count), 64'((fl_n > 255) ? 255 : fl_n));
`endif
                $display("%0d/%0d checks passed", n_pass, n_chk);
                $finish;
            end

            // ---------------- reference model and monitor ----------------
            forever begin
                @(negedge clk);
                if (rst) begin
                    rd_ptr   = wr_ptr;
                    acc_n    = 0;
                    pop_pend = 1'b0;
                    hs_n     = 0;
                    fl_n     = 0;
                end else begin
                    if (out_valid) begin
                        if (rd_ptr == wr_ptr) begin
                            n_chk++;
                            $display("FAIL sb_unexpected_word: got 0x%0h, expected no word", out_data);
                        end else begin
                            chk("sb_data",  64'(out_data),  exp_data[rd_ptr % SBN]);
                            chk("sb_bytes", 64'(out_bytes), 64'(exp_bytes[rd_ptr % SBN]));
                            if (out_ready) begin
                                hs_n++;
                                if (exp_fl[rd_ptr % SBN]) fl_n++;
                                rd_ptr++;
                            end
                        end
                    end
                    if (flush && (acc_n > 0)) emit(1'b1);
                    if (lifo_rd_en) begin
                        chk("rd_while_empty",     64'(lifo_empty),         64'd0);
                        chk("rd_while_word_held", 64'(rd_ptr != wr_ptr),   64'd0);
                        if (!lifo_empty) begin
                            nb           = stack[push_cnt - pop_cnt - 1];
                            pop_pend     = 1'b1;
                            acc_b[acc_n] = nb;
                            acc_n++;
                            if (acc_n == BPW) emit(1'b0);
                        end
                    end
                end
            end

            // ---------------- LIFO read port (one-cycle latency) ----------------
            forever begin
                @(posedge clk);
                if (pop_pend) begin
                    lifo_data <= nb;
                    pop_cnt   <= pop_cnt + 1;
                    pop_pend   = 1'b0;
                end
            end

            // ---------------- watchdog ----------------
            begin
                #500000;
                $display("FAIL watchdog: got timeout, expected end of test");
                $display("%0d/%0d checks passed", n_pass, n_chk);
                $fatal(1, "watchdog expired");
            end
        join
    end

endmodule
`default_nettype wire
